// File: rtl/cpu_pkg.sv
// Shared types for the pipeline hazard/sequencing controller.
package cpu_pkg;

  // E-stage ALU operand source select.
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_t;

  // Data-memory wait FSM states.
  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/forward_unit.sv
// Forwarding select for one E-stage ALU operand; M result wins over W result.
module forward_unit
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rsE,
  input  logic [REG_ADDR_WIDTH-1:0] rdM,
  input  logic [REG_ADDR_WIDTH-1:0] rdW,
  input  logic                      regWriteM,
  input  logic                      regWriteW,
  output fwd_sel_t                  fwdSel
);

  // Priority compare; x0 is never a forwarding source.
  always_comb begin
    fwdSel = FWD_REG;
    if (regWriteM && (rdM != '0) && (rdM == rsE)) begin
      fwdSel = FWD_M;
    end else if (regWriteW && (rdW != '0) && (rdW == rsE)) begin
      fwdSel = FWD_W;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: forwarding,
// load-use and branch hazards, data-memory wait freeze with timeout, and
// stall/flush performance counters.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_RUN      | normal flow; a pending M access that is not ready freezes
// ST_MEM_WAIT | pipeline frozen until MemReadyM or the wait budget expires
module pipeline_ctrl
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
  input  logic [REG_ADDR_WIDTH-1:0] RdE,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic                      RegWriteM,
  input  logic                      RegWriteW,
  input  logic                      LoadE,
  input  logic                      PCSrcE,
  input  logic                      MemReqM,
  input  logic                      MemReadyM,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      StallE,
  output logic                      StallM,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic                      FlushW,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE,
  output logic                      MemErr,
  output logic [DATA_WIDTH-1:0]     StallCount,
  output logic [DATA_WIDTH-1:0]     FlushCount
);

  localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [DATA_WIDTH-1:0] CTR_ONE = DATA_WIDTH'(1);

  mem_state_t       state;
  mem_state_t       stateNext;
  logic [CNT_W-1:0] waitCnt;
  logic [CNT_W-1:0] waitCntNext;
  logic             memStall;
  logic             timeout;
  logic             lwStall;
  fwd_sel_t         fwdA;
  fwd_sel_t         fwdB;

  forward_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) uFwdA (
    .rsE       (Rs1E),
    .rdM       (RdM),
    .rdW       (RdW),
    .regWriteM (RegWriteM),
    .regWriteW (RegWriteW),
    .fwdSel    (fwdA)
  );

  forward_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) uFwdB (
    .rsE       (Rs2E),
    .rdM       (RdM),
    .rdW       (RdW),
    .regWriteM (RegWriteM),
    .regWriteW (RegWriteW),
    .fwdSel    (fwdB)
  );

  assign lwStall = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // Memory-wait next state. waitCnt counts elapsed wait cycles of the current
  // access, including the RUN cycle that first saw the access not ready, so
  // the pipeline is frozen for at most MEM_TIMEOUT-1 cycles and released in
  // the MEM_TIMEOUT-th.
  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    memStall    = 1'b0;
    timeout     = 1'b0;
    case (state)
      ST_RUN: begin
        waitCntNext = '0;
        if (MemReqM && !MemReadyM) begin
          memStall    = 1'b1;
          stateNext   = ST_MEM_WAIT;
          waitCntNext = CNT_ONE;
        end
      end
      ST_MEM_WAIT: begin
        if (MemReadyM) begin
          stateNext   = ST_RUN;
          waitCntNext = '0;
        end else if (waitCnt == CNT_LAST) begin
          timeout     = 1'b1;
          stateNext   = ST_RUN;
          waitCntNext = '0;
        end else begin
          memStall    = 1'b1;
          waitCntNext = waitCnt + CNT_ONE;
        end
      end
      default: begin
        stateNext   = ST_RUN;
        waitCntNext = '0;
      end
    endcase
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_RUN;
      waitCnt <= '0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
    end
  end

  // Prioritised stall/flush/forward outputs; reset holds the pipe flushed.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = FWD_REG;
    ForwardBE = FWD_REG;
    if (!rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else begin
      ForwardAE = fwdA;
      ForwardBE = fwdB;
      if (memStall) begin
        // E is frozen, so a redirect in E waits until the release cycle.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        // The timed-out access advances out of M but must not retire.
        FlushW = timeout;
        if (PCSrcE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (lwStall) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
    end
  end

  // Sticky memory-timeout error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MemErr <= 1'b0;
    end else if (timeout) begin
      MemErr <= 1'b1;
    end
  end

  // Stall and flush cycle counters, wrapping naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (StallF) begin
        StallCount <= StallCount + CTR_ONE;
      end
      if (FlushD || FlushE) begin
        FlushCount <= FlushCount + CTR_ONE;
      end
    end
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipelined CPU (F/D/E/M/W).
- Drives per-stage stall and flush controls, and the forwarding selects for the E-stage ALU operands.
- Runs a small FSM that freezes the pipeline while a data-memory access in M waits for its ready handshake, with a timeout.
- Keeps performance counters for stall and flush cycles.

Parameters:
- DATA_WIDTH, 32, width of the performance counters.
- REG_ADDR_WIDTH, 5, width of architectural register indices.
- MEM_TIMEOUT, 16, maximum number of MEM_WAIT cycles before a forced release (must be >= 2).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- Rs1D, Rs2D  in  REG_ADDR_WIDTH  source registers of the instruction in D
- Rs1E, Rs2E, RdE  in  REG_ADDR_WIDTH  source and destination registers in E
- RdM, RdW  in  REG_ADDR_WIDTH  destination registers in M and W
- RegWriteM, RegWriteW  in  1  register-write enables in M and W
- LoadE  in  1  the instruction in E is a load
- PCSrcE  in  1  taken branch or jump resolved in E
- MemReqM  in  1  the instruction in M accesses data memory
- MemReadyM  in  1  data memory completes the access this cycle
- StallF, StallD, StallE, StallM  out  1  hold the named stage's pipeline register
- FlushD, FlushE, FlushW  out  1  insert a bubble into the named stage's register
- ForwardAE, ForwardBE  out  2  operand select: 00 = register file, 01 = W result, 10 = M ALU result
- MemErr  out  1  sticky flag: a memory timeout occurred
- StallCount, FlushCount  out  DATA_WIDTH  performance counters

Behaviour:
- Forwarding (combinational, operand A shown; B is identical using Rs2E):
  - ForwardAE = 10 if RegWriteM, RdM != 0 and RdM == Rs1E.
  - Otherwise 01 if RegWriteW, RdW != 0 and RdW == Rs1E.
  - Otherwise 00.
  - M has priority over W.
- Load-use: lwStall = LoadE & (RdE != 0) & (RdE == Rs1D | RdE == Rs2D).
- memStall:
  - Asserted in RUN when MemReqM & !MemReadyM.
  - Asserted in MEM_WAIT when !MemReadyM & !timeout.
- Output priority:
  1. memStall: StallF = StallD = StallE = StallM = 1, FlushW = 1, FlushD = FlushE = 0. PCSrcE is ignored because E is frozen; it is re-evaluated after release.
  2. PCSrcE: FlushD = FlushE = 1, no stalls. The redirect must win over lwStall.
  3. lwStall: StallF = StallD = 1, FlushE = 1.
  4. Otherwise all controls are 0.
- FSM states:
  - RUN: goes to MEM_WAIT when MemReqM & !MemReadyM; wait_cnt is cleared.
  - MEM_WAIT: wait_cnt increments each cycle.
    - MemReadyM = 1 -> RUN. Stall controls drop in this same cycle and the access completes.
    - wait_cnt == MEM_TIMEOUT-1 with !MemReadyM -> timeout: MemErr <= 1 (sticky), RUN, and stalls drop in this cycle so M advances. FlushW = 1 in this cycle.
- Latency: stall and flush controls are combinational from inputs plus current state. No added cycle.
- Counters:
  - StallCount increments on every cycle with StallF = 1.
  - FlushCount increments on every cycle with FlushD | FlushE.
  - Both wrap modulo 2^DATA_WIDTH.
- Reset (rst = 0), asynchronous, including mid-MEM_WAIT:
  - State = RUN, wait_cnt = 0, MemErr = 0, counters = 0.
  - While rst is low, outputs are forced to stalls = 0, FlushD = FlushE = FlushW = 1, Forward* = 00.
  - Normal operation starts on the first edge after release.
- x0: a destination of 0 never forwards and never causes a stall.

Decomposition:
- Shared package cpu_pkg holds the fwd_sel_t enum (FWD_REG = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10) and the memory-FSM state enum.
- One sub-module, forward_unit, provides the combinational forwarding for one operand and is instantiated twice.
- The FSM, priority logic and counters stay in pipeline_ctrl.

Test Plan:
- Forwarding: RdM = 5, RegWriteM = 1, RdW = 5, RegWriteW = 1, Rs1E = 5 -> ForwardAE = 10. Drop RegWriteM -> ForwardAE = 01. Set RdM = RdW = 0 -> ForwardAE = 00.
- Load-use: LoadE = 1, RdE = 7, Rs2D = 7 -> StallF = StallD = FlushE = 1 for one cycle, StallCount += 1. Same with RdE = 0 -> no stall.
- Branch with load-use: PCSrcE = 1 while lwStall conditions hold -> FlushD = FlushE = 1, StallF = 0, FlushCount += 1.
- Memory wait: MemReqM = 1, MemReadyM low for 3 cycles then high -> all stalls plus FlushW high for 3 cycles, low in the ready cycle, state back in RUN, StallCount = 3. A simultaneous PCSrcE produces no flush until after release.
- Timeout: MEM_TIMEOUT = 4, MemReqM = 1, MemReadyM stays 0 -> stalls high for 3 cycles and drop on the 4th, MemErr = 1 from then on and remains 1.
- Reset mid-wait: assert rst = 0 during MEM_WAIT -> immediate RUN, stalls 0, FlushD/E/W = 1, counters and MemErr = 0.
